vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-mode VGA draw block.
- Generates H/V timing for any resolution, porch set and sync polarity.
- Requests pixels from a renderer PIPE_LAT cycles ahead of display and aligns the returned RGB with delayed sync/valid.
- Sits between renderer logic (game/menu drawing) and the board VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of vga_hsync
- VS_POL, 0, active level of vga_vsync
- RGB_W, 16, colour word width (RGB565 default)
- X_W, 10, width of ovga_x
- Y_W, 10, width of ovga_y
- PIPE_LAT, 1, renderer latency in clocks, legal 0..7

Ports:
- iVGA_CLK  in  1  pixel clock, all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- iColor_SW  in  1  test-pattern select (used only with VGA_TEST_PATTERN_EN)
- irgb  in  RGB_W  renderer colour for the request issued PIPE_LAT cycles earlier
- ovga_x  out  X_W  requested pixel column
- ovga_y  out  Y_W  requested pixel row
- oreq  out  1  request strobe, high in active region
- oframe_start  out  1  one-cycle pulse at h=0,v=0 (request side)
- oline_start  out  1  one-cycle pulse at h=0 of every line
- vga_rgb  out  RGB_W  displayed colour
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_valid  out  1  display enable, aligned with vga_rgb

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Region order: active, front porch, sync, back porch.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps; vcnt wraps from V_TOTAL-1 to 0 on the same edge hcnt wraps.
- Request side (combinational from registered counters):
  - oreq = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
  - ovga_x = hcnt and ovga_y = vcnt when oreq; both 0 otherwise.
- Sync raw levels:
  - hs_raw is active when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw follows the same rule on vcnt.
  - Each raw level is XORed to the declared polarity.
- Alignment:
  - oreq, hs_raw and vs_raw pass through a PIPE_LAT+1 stage delay line.
  - irgb is sampled at request+PIPE_LAT and registered once.
  - vga_rgb/vga_valid/sync therefore appear PIPE_LAT+1 clocks after the matching request.
- Blanking: vga_rgb = 0 whenever delayed valid is 0; irgb is ignored then.
- Reset (async assert, sync release):
  - hcnt=vcnt=0, all delay stages cleared to inactive.
  - vga_rgb=0, vga_valid=0, oframe_start=0, oline_start=0.
  - vga_hsync=~HS_POL, vga_vsync=~VS_POL.
- Reset mid-frame: everything returns to the reset state in the same instant. The first cycle after release is h=0,v=0, so oreq=1 and oframe_start=1.
- Elaboration error if PIPE_LAT>7, or if X_W/Y_W cannot hold H_ACTIVE-1/V_ACTIVE-1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- With the macro: when iColor_SW=1, irgb is replaced at the delay tap by 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black (RGB565 full-scale values).
  - The bars keep identical latency to the irgb path.
- Without the macro: iColor_SW is ignored and the bar logic is absent.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants
  - RGB565 colour constants (white/black/primaries)
  - a function computing a total from active+porches+sync
- Sub-module vga_delay_line: a parametrised W-bit, N-stage shift register with async reset value. It is instantiated for the valid/sync bundle.

Test Plan:
- Small mode (H 8/2/3/3, V 4/1/2/1, PIPE_LAT=1), release reset:
  - oframe_start pulses on the first cycle.
  - oline_start repeats every 16 clocks.
  - oframe_start repeats every 128 clocks.
- Same mode, irgb = {x,y} echo:
  - vga_valid rises 2 clocks after oreq.
  - The first displayed word equals the echo for (0,0).
  - vga_rgb=0 in blanking even when irgb=16'hFFFF.
- Polarity: HS_POL=0, hcnt 10..12 gives vga_hsync low for exactly 3 clocks, delayed by 2. With HS_POL=1 the pulse is high.
- Assert sys_rst at hcnt=5,vcnt=2, hold 3 clocks:
  - outputs go immediately to reset values (hsync=~HS_POL, rgb=0).
  - Timing restarts at (0,0) on release.
- Sweep PIPE_LAT=0 and 7: measured latency from oreq to vga_valid equals PIPE_LAT+1.
- VGA_TEST_PATTERN_EN with iColor_SW=1, H_ACTIVE=8: displayed pixels 0..7 equal FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB565 colour constants and timing helpers.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// W-bit, N-stage shift register with asynchronous reset to RST_VAL; every stage is exposed.
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             N       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] taps [N]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) taps[i] <= RST_VAL;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with renderer request look-ahead and aligned RGB output.
// Optional colour-bar test pattern is built when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 16,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int PIPE_LAT = 1
) (
    input  logic             iVGA_CLK,
    input  logic             sys_rst,
    input  logic             iColor_SW,
    input  logic [RGB_W-1:0] irgb,
    output logic [X_W-1:0]   ovga_x,
    output logic [Y_W-1:0]   ovga_y,
    output logic             oreq,
    output logic             oframe_start,
    output logic             oline_start,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_valid
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_CW    = cnt_width(H_TOTAL);
    localparam int V_CW    = cnt_width(V_TOTAL);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    generate
        if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_lat
            $error("vga_timing_gen: PIPE_LAT must be 0..7");
        end
        if (H_ACTIVE - 1 >= (2 ** X_W)) begin : g_bad_xw
            $error("vga_timing_gen: X_W too narrow for H_ACTIVE");
        end
        if (V_ACTIVE - 1 >= (2 ** Y_W)) begin : g_bad_yw
            $error("vga_timing_gen: Y_W too narrow for V_ACTIVE");
        end
    endgenerate

    logic [H_CW-1:0] hcnt;
    logic [V_CW-1:0] vcnt;
    int              h_i;
    int              v_i;

    assign h_i = int'(hcnt);
    assign v_i = int'(vcnt);

    always_ff @(posedge iVGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_i == H_TOTAL - 1) begin
            hcnt <= '0;
            vcnt <= (v_i == V_TOTAL - 1) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    logic req_raw;
    logic hs_raw;
    logic vs_raw;

    assign req_raw = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    assign hs_raw  = (h_i >= HS_BEG) && (h_i < HS_END);
    assign vs_raw  = (v_i >= VS_BEG) && (v_i < VS_END);

    // Counters already sit at (0,0) during reset; gating keeps the strobes quiet until release.
    assign oreq         = req_raw && !sys_rst;
    assign oline_start  = (h_i == 0) && !sys_rst;
    assign oframe_start = (h_i == 0) && (v_i == 0) && !sys_rst;
    assign ovga_x       = oreq ? X_W'(hcnt) : '0;
    assign ovga_y       = oreq ? Y_W'(vcnt) : '0;

`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W  = 6;
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_W'(RGB565_WHITE);
            3'd1:    return RGB_W'(RGB565_YELLOW);
            3'd2:    return RGB_W'(RGB565_CYAN);
            3'd3:    return RGB_W'(RGB565_GREEN);
            3'd4:    return RGB_W'(RGB565_MAGENTA);
            3'd5:    return RGB_W'(RGB565_RED);
            3'd6:    return RGB_W'(RGB565_BLUE);
            default: return RGB_W'(RGB565_BLACK);
        endcase
    endfunction

    int         bar_i;
    logic [2:0] bar_idx;
    assign bar_i   = h_i / BAR_W;
    assign bar_idx = (bar_i > 7) ? 3'd7 : 3'(bar_i);
`else
    localparam int DL_W = 3;
`endif

    logic [DL_W-1:0] dl_in;
    logic [DL_W-1:0] dl_taps [PIPE_LAT+1];
    logic [DL_W-1:0] dl_out;
    logic [DL_W-1:0] dl_tap;

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {req_raw, hs_raw, vs_raw, bar_idx};
`else
    assign dl_in = {req_raw, hs_raw, vs_raw};
`endif

    vga_delay_line #(
        .W (DL_W),
        .N (PIPE_LAT + 1)
    ) u_delay (
        .clk  (iVGA_CLK),
        .rst  (sys_rst),
        .din  (dl_in),
        .taps (dl_taps)
    );

    // The tap one stage ahead of the output lines up with the renderer's returned colour.
    generate
        if (PIPE_LAT == 0) begin : g_tap_direct
            assign dl_tap = dl_in;
        end else begin : g_tap_stage
            assign dl_tap = dl_taps[PIPE_LAT-1];
        end
    endgenerate

    assign dl_out = dl_taps[PIPE_LAT];

    logic [RGB_W-1:0] pix;
    logic [RGB_W-1:0] rgb_q;

`ifdef VGA_TEST_PATTERN_EN
    logic unused_tail;
    assign pix         = iColor_SW ? bar_colour(dl_tap[2:0]) : irgb;
    assign unused_tail = ^{dl_out[2:0], dl_tap[4:3]};
`else
    logic unused_tail;
    assign pix         = irgb;
    assign unused_tail = ^{iColor_SW, dl_tap[1:0]};
`endif

    always_ff @(posedge iVGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= dl_tap[DL_W-1] ? pix : '0;
        end
    end

    assign vga_rgb   = rgb_q;
    assign vga_valid = dl_out[DL_W-1];
    assign vga_hsync = dl_out[DL_W-2] ^ ~HS_POL;
    assign vga_vsync = dl_out[DL_W-3] ^ ~VS_POL;

endmodule
